// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - 68000 bus cycle sequencer between CPU pins and the chip bus decoder
module cpu_bus_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int HOLD    = 1
) (
    input  logic clk,
    input  logic _reset,
    input  logic _as,
    input  logic _uds,
    input  logic _lds,
    input  logic r_w,
    input  logic sel,
    input  logic cpuok,
    output logic cpurd,
    output logic cpuhwr,
    output logic cpulwr,
    output logic _dtack,
    output logic _berr,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        ACCESS = 3'd2,
        ACK    = 3'd3,
        BERR   = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t     state;
    logic [7:0] tcnt;
    logic [3:0] hcnt;
    logic       dtack_q;
    logic       berr_q;
    logic       busy_q;
    logic       null_write;
    logic       strobe_en;

    assign null_write = !r_w && _uds && _lds;

    // Strobes stay combinational so they follow cpuok exactly and never spill into a DMA slot;
    // a released _as kills them in the same cycle.
    assign strobe_en = (state == ACCESS) && cpuok && !_as;
    assign cpurd     = strobe_en && r_w;
    assign cpuhwr    = strobe_en && !r_w && !_uds;
    assign cpulwr    = strobe_en && !r_w && !_lds;

    assign _dtack = dtack_q;
    assign _berr  = berr_q;
    assign busy   = busy_q;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state   <= IDLE;
            tcnt    <= '0;
            hcnt    <= '0;
            dtack_q <= 1'b1;
            berr_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!_as) begin
                        state  <= ARB;
                        tcnt   <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ARB: begin
                    if (_as) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (sel && cpuok) begin
                        if (null_write) begin
                            state   <= ACK;
                            dtack_q <= 1'b0;
                        end else begin
                            state <= ACCESS;
                            hcnt  <= '0;
                        end
                    end else if (!sel) begin
                        // Only unselected cycles count toward the bus error; a select that
                        // is merely waiting for its slot never times out.
                        if (tcnt == TMO_LAST) begin
                            state  <= BERR;
                            berr_q <= 1'b0;
                        end else begin
                            tcnt <= tcnt + 8'd1;
                        end
                    end
                end
                ACCESS: begin
                    if (_as) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (cpuok) begin
                        if (hcnt == HOLD_LAST) begin
                            state   <= ACK;
                            dtack_q <= 1'b0;
                        end else begin
                            hcnt <= hcnt + 4'd1;
                        end
                    end
                end
                ACK: begin
                    if (_as) begin
                        state   <= IDLE;
                        dtack_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                BERR: begin
                    if (_as) begin
                        state  <= IDLE;
                        berr_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    dtack_q <= 1'b1;
                    berr_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb/tb_cpu_bus_ctrl.sv - scoreboard bench for cpu_bus_ctrl with randomized bus cycles
module tb_cpu_bus_ctrl;

    localparam int TIMEOUT = 64;
    localparam int HOLD    = 2;
    localparam int LEN     = 400;

    logic clk = 1'b0;
    logic rst_n, as_n, uds_n, lds_n, r_w, sel, cpuok;
    logic cpurd, cpuhwr, cpulwr, dtack_n, berr_n, busy;

    cpu_bus_ctrl #(.TIMEOUT(TIMEOUT), .HOLD(HOLD)) dut (
        .clk(clk), ._reset(rst_n), ._as(as_n), ._uds(uds_n), ._lds(lds_n), .r_w(r_w),
        .sel(sel), .cpuok(cpuok), .cpurd(cpurd), .cpuhwr(cpuhwr), .cpulwr(cpulwr),
        ._dtack(dtack_n), ._berr(berr_n), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d_rel; int b_rel; int dlow; int blow; int nrd; int nhw; int nlw;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   s_sel[LEN];
    bit   s_ok[LEN];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: collects one bus cycle (busy high span) and compares it to the scoreboard head.
    bit   in_txn = 1'b0;
    exp_t got;
    int   rel, ovl;
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            in_txn = 1'b0;
        end else if (busy) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                rel = 0; ovl = 0;
                got = '{-1, -1, 0, 0, 0, 0, 0};
            end
            if (!dtack_n && got.d_rel < 0) got.d_rel = rel;
            if (!berr_n && got.b_rel < 0) got.b_rel = rel;
            if (!dtack_n) got.dlow++;
            if (!berr_n) got.blow++;
            if (!dtack_n && !berr_n) ovl++;
            got.nrd += int'(cpurd);
            got.nhw += int'(cpuhwr);
            got.nlw += int'(cpulwr);
            rel++;
        end else if (in_txn) begin
            in_txn = 1'b0;
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dtack_cycle", got.d_rel, e.d_rel);
                check("berr_cycle", got.b_rel, e.b_rel);
                check("dtack_len", got.dlow, e.dlow);
                check("berr_len", got.blow, e.blow);
                check("cpurd_cycles", got.nrd, e.nrd);
                check("cpuhwr_cycles", got.nhw, e.nhw);
                check("cpulwr_cycles", got.nlw, e.nlw);
                check("ack_overlap", ovl, 0);
            end
        end
    end

    // mode 0: immediate grant; 1: random DMA stalls; 2: never selected; 3: 200-cycle wait;
    // 4: random select and grant; 5: fixed stall 0,0,0 then grant, then 1,0,1 in the access
    task automatic run_txn(input int mode, input bit rd, input int wpat,
                           input bit ab, input int ab_at, input int extra);
        exp_t e;
        int   g, zeros, bt, term, n, t, ext;
        bit   nullw, acked, done, do_ab;
        for (int j = 0; j < LEN; j++) begin
            case (mode)
                0: begin s_sel[j] = 1'b1; s_ok[j] = 1'b1; end
                1: begin s_sel[j] = 1'b1; s_ok[j] = (j < 2) ? 1'b0 : 1'($urandom_range(0, 1)); end
                2: begin s_sel[j] = 1'b0; s_ok[j] = 1'($urandom_range(0, 1)); end
                3: begin s_sel[j] = 1'b1; s_ok[j] = (j >= 200); end
                4: begin s_sel[j] = 1'($urandom_range(0, 1)); s_ok[j] = 1'($urandom_range(0, 1)); end
                default: begin s_sel[j] = 1'b1; s_ok[j] = !(j < 3 || j == 5); end
            endcase
        end
        if (rd) begin
            uds_n = 1'($urandom_range(0, 1));
            lds_n = 1'($urandom_range(0, 1));
        end else begin
            uds_n = (wpat == 2 || wpat == 3);
            lds_n = (wpat == 1 || wpat == 3);
        end
        nullw = !rd && uds_n && lds_n;

        // Reference: first granted ARB cycle vs. the TIMEOUT-th unselected one, then HOLD grants.
        g = -1; bt = -1; zeros = 0; term = 1000;
        for (int j = 0; j < LEN; j++) begin
            if (s_sel[j] && s_ok[j]) begin g = j; break; end
            if (!s_sel[j]) begin
                zeros++;
                if (zeros == TIMEOUT) begin bt = j; break; end
            end
        end
        if (bt >= 0) term = bt + 1;
        else if (g >= 0 && nullw) term = g + 1;
        else if (g >= 0) begin
            n = 0;
            for (int k = g + 1; k < LEN; k++) begin
                if (s_ok[k]) n++;
                if (n == HOLD) begin term = k + 1; break; end
            end
        end

        do_ab = ab && ab_at < term;
        e = '{-1, -1, 0, 0, 0, 0, 0};
        n = 0;
        if (do_ab) begin
            if (bt < 0 && g >= 0 && !nullw)
                for (int k = g + 1; k < ab_at; k++) if (s_ok[k]) n++;
        end else if (bt >= 0) begin
            e.b_rel = term; e.blow = extra + 2;
        end else begin
            e.d_rel = term; e.dlow = extra + 2;
            if (!nullw) n = HOLD;
        end
        if (rd) e.nrd = n;
        else begin
            e.nhw = uds_n ? 0 : n;
            e.nlw = lds_n ? 0 : n;
        end
        sb.push_back(e);

        r_w = rd;
        @(posedge clk); #1;
        as_n = 1'b0;
        t = 0; acked = 1'b0; done = 1'b0; ext = extra;
        while (!done) begin
            @(posedge clk); #1;
            if ((do_ab && t == ab_at) || (acked && ext == 0)) begin
                as_n = 1'b1;
                done = 1'b1;
            end else begin
                if (acked) ext--;
                sel   = (t < LEN) ? s_sel[t] : 1'b1;
                cpuok = (t < LEN) ? s_ok[t] : 1'b1;
            end
            @(negedge clk);
            if (!dtack_n || !berr_n) acked = 1'b1;
            t++;
            if (!done && t >= LEN) begin
                n_cmp++; n_bad++;
                $display("FAIL txn_bound: no termination after %0d cycles, expected by %0d", t, term);
                as_n = 1'b1;
                done = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; r_w = 1'b1; sel = 1'b0; cpuok = 1'b0;
        #12;
        check("rst_cpurd", cpurd, 0);
        check("rst_cpuhwr", cpuhwr, 0);
        check("rst_cpulwr", cpulwr, 0);
        check("rst_dtack", dtack_n, 1);
        check("rst_berr", berr_n, 1);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        run_txn(0, 1'b1, 0, 1'b0, 0, 0);     // word read
        run_txn(5, 1'b0, 1, 1'b0, 0, 1);     // upper-byte write through DMA stalls
        run_txn(2, 1'b1, 0, 1'b0, 0, 0);     // decoder never selects
        run_txn(3, 1'b0, 0, 1'b0, 0, 0);     // long wait with select held
        run_txn(0, 1'b1, 0, 1'b1, 2, 0);     // abort mid-access
        run_txn(0, 1'b0, 3, 1'b0, 0, 2);     // null write

        for (int i = 0; i < 60; i++) begin
            int r, mode;
            r = $urandom_range(0, 19);
            mode = (r < 8) ? 0 : (r < 14) ? 1 : (r < 18) ? 4 : (r == 18) ? 2 : 3;
            run_txn(mode, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0), $urandom_range(0, 6), $urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        check("sb_empty", sb.size(), 0);

        // Asynchronous reset while the CPU is being acknowledged.
        mon_en = 1'b0;
        @(posedge clk); #1;
        r_w = 1'b1; sel = 1'b1; cpuok = 1'b1; as_n = 1'b0;
        for (int i = 0; i < 20 && dtack_n; i++) @(negedge clk);
        check("areset_in_ack", dtack_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_dtack", dtack_n, 1);
        check("areset_berr", berr_n, 1);
        check("areset_busy", busy, 0);
        check("areset_cpurd", cpurd, 0);
        as_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
